// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and the default datapath width.
package alu_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters (master) and the arbiter
// (slave). Both requesters share one interface instance.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2:0]       req_op0;
  logic [2:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU block. It only computes the legal operations; opcode
// legality and zero detection are decided by the instantiating block.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  // Select the operation result; unknown opcodes yield all zeros.
  always_comb begin
    res = {WIDTH{1'b0}};
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT: begin
        if (a < b) begin
          res = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          res = {WIDTH{1'b0}};
        end
      end
      default: res = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single ALU. One operation is in
// flight at a time: accept in IDLE, compute in EXEC, hold response in RESP.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic             last_grant_r;
  logic             grant_valid_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [1:0]       ready_s;
  logic             rsp_valid_s;

  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             id_r;

  logic [WIDTH-1:0] alu_res_s;
  logic             legal_s;
  logic [WIDTH-1:0] res_value_s;

  logic [WIDTH-1:0] rsp_res_r;
  logic             rsp_zero_r;
  logic             rsp_err_r;
  logic             rsp_id_r;

  // True for the opcodes the ALU implements.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Full-width zero detect.
  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return ~(|v);
  endfunction

  // Pick the winner among valid requesters; a tie goes to the one not served last.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    case (bus.req_valid)
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~last_grant_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    endcase
  end

  assign accept_s = (state_r == ST_IDLE) && grant_valid_s && !reset;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only for the granted requester in IDLE, valid only in RESP.
  always_comb begin
    ready_s     = 2'b00;
    rsp_valid_s = 1'b0;
    if (reset) begin
      ready_s     = 2'b00;
      rsp_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            ready_s = grant_id_s ? 2'b10 : 2'b01;
          end else begin
            ready_s = 2'b00;
          end
        end
        ST_RESP: rsp_valid_s = 1'b1;
        default: begin
          ready_s     = 2'b00;
          rsp_valid_s = 1'b0;
        end
      endcase
    end
  end

  // Capture the granted request and remember who was served.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r         <= 3'b000;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      op_r         <= grant_id_s ? bus.req_op1 : bus.req_op0;
      a_r          <= grant_id_s ? bus.req_a1 : bus.req_a0;
      b_r          <= grant_id_s ? bus.req_b1 : bus.req_b0;
      id_r         <= grant_id_s;
      last_grant_r <= grant_id_s;
    end else begin
      op_r         <= op_r;
      a_r          <= a_r;
      b_r          <= b_r;
      id_r         <= id_r;
      last_grant_r <= last_grant_r;
    end
  end

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op  (op_r),
    .a   (a_r),
    .b   (b_r),
    .res (alu_res_s)
  );

  assign legal_s     = op_is_legal(op_r);
  assign res_value_s = legal_s ? alu_res_s : {WIDTH{1'b0}};

  // Load the response registers during EXEC; they hold through RESP and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_res_r  <= {WIDTH{1'b0}};
      rsp_zero_r <= 1'b0;
      rsp_err_r  <= 1'b0;
      rsp_id_r   <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      rsp_res_r  <= res_value_s;
      rsp_zero_r <= is_zero(res_value_s);
      rsp_err_r  <= ~legal_s;
      rsp_id_r   <= id_r;
    end else begin
      rsp_res_r  <= rsp_res_r;
      rsp_zero_r <= rsp_zero_r;
      rsp_err_r  <= rsp_err_r;
      rsp_id_r   <= rsp_id_r;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_res   = rsp_res_r;
  assign bus.rsp_zero  = rsp_zero_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_id    = rsp_id_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-006 req_op0, req_op1  in  3 each  ALU opcode per requester.
REQ-007 req_a0, req_b0, req_a1, req_b1  in  WIDTH each  operands per requester.
REQ-008 rsp_valid  out  1  response valid.
REQ-009 rsp_ready  in  1  response consumer accept.
REQ-010 rsp_id  out  1  requester index that owns the response.
REQ-011 rsp_res  out  WIDTH  ALU result.
REQ-012 rsp_zero  out  1  high when rsp_res == 0 across all WIDTH bits.
REQ-013 rsp_err  out  1  high when the accepted opcode was illegal.

Function
REQ-014 FSM states: IDLE, EXEC, RESP.
REQ-015 IDLE: req_ready[i] = 1 only for the granted requester; all other bits 0. EXEC and RESP: req_ready = 2'b00.
REQ-016 Grant in IDLE: a lone valid requester wins. On a tie, the requester not equal to last_grant wins (round-robin).
REQ-017 Handshake: req_ready does not depend on rsp_ready. A requester keeps its valid and operands stable until accepted.
REQ-018 On accept: capture op, a, b and id into registers; set last_grant = id; IDLE -> EXEC.
REQ-019 EXEC, one cycle: evaluate the captured operands and load rsp_res, rsp_zero, rsp_err and rsp_id into registers; EXEC -> RESP.
REQ-020 Opcodes: 000 AND, 001 OR, 010 ADD (mod 2^WIDTH, carry dropped), 110 SUB (mod 2^WIDTH), 111 set-less-than, unsigned, result 1 or 0 zero-extended.
REQ-021 Any other opcode: rsp_res = 0, rsp_zero = 1, rsp_err = 1. All legal opcodes give rsp_err = 0.
REQ-022 RESP: rsp_valid = 1 and all rsp_* outputs held stable. When rsp_ready = 1 at an edge: RESP -> IDLE. Otherwise stay in RESP.
REQ-023 Latency: accept at edge N gives rsp_valid high from edge N+2. The earliest next accept is at edge N+3 with rsp_ready tied high.
REQ-024 Only one operation is outstanding at a time; no new request is accepted before the response handshake completes.
REQ-025 rsp_valid is low in IDLE and EXEC. rsp_* values outside RESP are don't-care for consumers but remain deterministic: they hold their last loaded values.
REQ-026 A requester that drops req_valid before being accepted loses no state; it is simply not granted.

Reset
REQ-027 While reset is high at an edge: state = IDLE, last_grant = 1 (so requester 0 wins the first tie), captured registers = 0.
REQ-028 The same reset edge also clears the outputs: rsp_res = 0, rsp_zero = 0, rsp_err = 0, rsp_id = 0, rsp_valid = 0.
REQ-029 Reset asserted in EXEC or RESP discards the in-flight operation; no response for it is ever produced.
REQ-030 req_ready is 2'b00 during any cycle in which reset is high.

Structure
REQ-031 A shared package holds: the opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT), the FSM state enum and the WIDTH default.
REQ-032 One sub-module: the codebase ALU block, instantiated once on the captured operands.
REQ-033 The illegal-opcode check and the full-width zero detection live in alu_arbiter; neither is delegated to the ALU.

Verification
REQ-034 Single request: requester 0, op 010, a = 0xFFFFFFFF, b = 1, accepted at edge N -> rsp_valid at edge N+2, rsp_res = 0, rsp_zero = 1, rsp_err = 0, rsp_id = 0.
REQ-035 Tie after reset: both requesters valid, op0 = 110 (5 - 3), op1 = 000 -> requester 0 served first (res = 2), then requester 1. With both still valid, the third grant goes to 0.
REQ-036 Backpressure: rsp_ready low for 4 cycles in RESP -> rsp_* outputs unchanged; req_ready = 00 throughout; a single handshake completes once rsp_ready rises.
REQ-037 Opcodes 111 and 011: a = 0x80000000, b = 1 with op 111 -> res = 0 (unsigned compare); op 011 -> res = 0, rsp_err = 1, rsp_zero = 1.
REQ-038 Reset mid-operation: reset pulsed in EXEC -> state returns to IDLE, rsp_valid never rises for that request, and the next tie is granted to requester 0.
